// File: rtl/rc4_xor_stream_if.sv
// Handshake bundle for rc4_xor_stream: keystream in, data in, result out.
// The master modport is the environment side; the slave modport is the XOR block.
interface rc4_xor_stream_if;
  logic [7:0] ks_data;
  logic       ks_valid;
  logic       ks_ready;

  logic [7:0] din_data;
  logic       din_last;
  logic       din_valid;
  logic       din_ready;

  logic [7:0] dout_data;
  logic       dout_last;
  logic       dout_valid;
  logic       dout_ready;

  modport master (
    output ks_data, ks_valid, din_data, din_last, din_valid, dout_ready,
    input  ks_ready, din_ready, dout_data, dout_last, dout_valid
  );

  modport slave (
    input  ks_data, ks_valid, din_data, din_last, din_valid, dout_ready,
    output ks_ready, din_ready, dout_data, dout_last, dout_valid
  );
endinterface

// File: rtl/rc4_xor_stream.sv
// XORs each data byte with one buffered RC4 keystream byte, with message framing.
// Optional macro RC4_DROP_EN discards the first DROP_N keystream bytes after reset.
module rc4_xor_stream #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16,
  parameter int DROP_N     = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  rc4_xor_stream_if.slave    bus,
  output logic [CNT_W-1:0]   byte_cnt,
  output logic               busy,
  output logic               done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             fifo_full, fifo_empty;
  logic             ks_fire, push, pop, din_fire, dout_fire, last_accept;

  logic [7:0]       dout_data_q;
  logic             dout_last_q, dout_valid_q, done_q;
  logic [CNT_W-1:0] byte_cnt_q;

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Readiness depends only on the full flag; a same-cycle pop never frees a slot early.
  assign bus.ks_ready = !fifo_full;
  assign ks_fire      = bus.ks_valid && !fifo_full;

`ifdef RC4_DROP_EN
  localparam int DROP_W = $clog2(DROP_N + 2);

  logic [DROP_W-1:0] drop_cnt_q;
  logic              dropping;

  assign dropping = (drop_cnt_q != DROP_W'(DROP_N));
  assign push     = ks_fire && !dropping;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (ks_fire && dropping) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end
`else
  assign push = ks_fire;
`endif

  assign bus.din_ready = (state_q == S_RUN) && !fifo_empty &&
                         (!dout_valid_q || bus.dout_ready);
  assign din_fire      = bus.din_valid && bus.din_ready;
  assign pop           = din_fire;
  assign dout_fire     = dout_valid_q && bus.dout_ready;
  assign last_accept   = (state_q == S_DRAIN) && dout_fire && dout_last_q;

  // NOTE: storage is written without reset; emptiness is tracked by count_q,
  // so stale entries are never read and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.ks_data;
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)                      state_d = S_RUN;
      S_RUN:   if (din_fire && bus.din_last)   state_d = S_DRAIN;
      S_DRAIN: if (last_accept)                state_d = S_IDLE;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Output register: a new load takes priority over the clear from a dout transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_data_q  <= '0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      byte_cnt_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      if (din_fire) begin
        dout_data_q  <= bus.din_data ^ fifo_mem[rd_ptr_q];
        dout_last_q  <= bus.din_last;
        dout_valid_q <= 1'b1;
      end else if (dout_fire) begin
        dout_valid_q <= 1'b0;
      end

      if ((state_q == S_IDLE) && start) begin
        byte_cnt_q <= '0;
      end else if (din_fire && (byte_cnt_q != '1)) begin
        byte_cnt_q <= byte_cnt_q + 1'b1;
      end

      done_q <= last_accept;
    end
  end

  assign bus.dout_data  = dout_data_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.dout_valid = dout_valid_q;
  assign byte_cnt       = byte_cnt_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Directed bench for rc4_xor_stream: known answer, starvation, backpressure,
// FIFO full/wrap, mid-message reset, and the keystream drop when enabled.
module tb_rc4_xor_stream;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] byte_cnt;
  logic        busy;
  logic        done;

  rc4_xor_stream_if bus ();

  rc4_xor_stream #(
    .FIFO_DEPTH (16),
    .CNT_W      (16),
    .DROP_N     (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .byte_cnt (byte_cnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ks_vec  [64];
  logic [7:0] din_vec [64];
  logic [7:0] exp_vec [64];
  logic [7:0] got     [$];

  localparam logic [7:0] KAT_KS [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
  localparam logic [7:0] KAT_PT [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  localparam logic [7:0] KAT_CT [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Pushes ks_vec[first .. first+n-1]; used only while the FIFO has room.
  task automatic push_ks(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ks_valid = 1'b1;
      bus.ks_data  = ks_vec[first + i];
      tick();
    end
    bus.ks_valid = 1'b0;
  endtask

  // Runs one message: din_vec[0..n-1] against exp_vec, optionally feeding
  // ks_vec[ks_first..ks_total-1] concurrently and stalling dout for a window.
  task automatic stream(input string tag, input int n, input int ks_first, input int ks_total,
                        input int stall_at, input int stall_len);
    int         di = 0;
    int         ki = ks_first;
    int         cyc = 0;
    int         last_idx = -1;
    bit         seen_done = 1'b0;
    bit         was_stalled = 1'b0;
    logic [7:0] held = '0;
    got.delete();
    pulse_start();
    while (!seen_done && cyc < 400) begin
      bus.din_valid  = (di < n);
      bus.din_data   = din_vec[di];
      bus.din_last   = (di == n - 1);
      bus.ks_valid   = (ki < ks_total);
      bus.ks_data    = ks_vec[ki];
      bus.dout_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (!bus.dout_ready && bus.dout_valid) begin
        check({tag, "_stall_din_ready"}, bus.din_ready, 1'b0);
        if (was_stalled) check({tag, "_stall_hold"}, bus.dout_data, held);
        held        = bus.dout_data;
        was_stalled = 1'b1;
      end else begin
        was_stalled = 1'b0;
      end
      if (bus.din_valid && bus.din_ready) di++;
      if (bus.ks_valid && bus.ks_ready) ki++;
      if (bus.dout_valid && bus.dout_ready) begin
        if (bus.dout_last) last_idx = got.size();
        got.push_back(bus.dout_data);
      end
      tick();
      if (done) seen_done = 1'b1;
      cyc++;
    end
    bus.din_valid  = 1'b0;
    bus.ks_valid   = 1'b0;
    bus.dout_ready = 1'b1;
    check({tag, "_done_seen"}, seen_done, 1'b1);
    check({tag, "_out_count"}, got.size(), n);
    check({tag, "_last_index"}, last_idx, n - 1);
    check({tag, "_byte_cnt"}, byte_cnt, n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s_dout[%0d]", tag, i), got[i], exp_vec[i]);
    end
    tick();
    check({tag, "_done_one_cycle"}, done, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ks_ready"},   bus.ks_ready,   1'b1);
    check({tag, "_din_ready"},  bus.din_ready,  1'b0);
    check({tag, "_dout_valid"}, bus.dout_valid, 1'b0);
    check({tag, "_dout_data"},  bus.dout_data,  8'h00);
    check({tag, "_dout_last"},  bus.dout_last,  1'b0);
    check({tag, "_byte_cnt"},   byte_cnt,       16'h0000);
    check({tag, "_busy"},       busy,           1'b0);
    check({tag, "_done"},       done,           1'b0);
  endtask

  initial begin
    bus.ks_data    = '0;
    bus.ks_valid   = 1'b0;
    bus.din_data   = '0;
    bus.din_last   = 1'b0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;

    // Reset state
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef RC4_DROP_EN
    // Drop: keystream 01..08 with the first four discarded
    for (int i = 0; i < 8; i++) ks_vec[i] = 8'(i + 1);
    push_ks(0, 8);
    for (int i = 0; i < 4; i++) din_vec[i] = 8'h00;
    exp_vec[0] = 8'h05; exp_vec[1] = 8'h06; exp_vec[2] = 8'h07; exp_vec[3] = 8'h08;
    stream("drop", 4, 8, 8, 1000, 0);
`endif

    // Known answer: key "Key", plaintext "Plaintext"
    for (int i = 0; i < 9; i++) ks_vec[i] = KAT_KS[i];
    push_ks(0, 9);
    pulse_start();
    check("kat_busy", busy, 1'b1);
    check("kat_cnt_clear", byte_cnt, 16'd0);
    for (int i = 0; i < 9; i++) begin
      bus.din_valid = 1'b1;
      bus.din_data  = KAT_PT[i];
      bus.din_last  = (i == 8);
      #1;
      check($sformatf("kat_din_ready[%0d]", i), bus.din_ready, 1'b1);
      tick();
      check($sformatf("kat_valid[%0d]", i), bus.dout_valid, 1'b1);
      check($sformatf("kat_dout[%0d]", i), bus.dout_data, KAT_CT[i]);
      check($sformatf("kat_last[%0d]", i), bus.dout_last, (i == 8));
      check($sformatf("kat_cnt[%0d]", i), byte_cnt, i + 1);
    end
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    #1;
    check("kat_drain_din_ready", bus.din_ready, 1'b0);
    check("kat_drain_busy", busy, 1'b1);
    tick();
    check("kat_done", done, 1'b1);
    check("kat_idle", busy, 1'b0);
    tick();
    check("kat_done_pulse", done, 1'b0);
    check("kat_byte_cnt", byte_cnt, 16'd9);

    // Keystream starvation
    pulse_start();
    bus.din_valid = 1'b1;
    bus.din_data  = 8'h0F;
    bus.din_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("starve_din_ready", bus.din_ready, 1'b0);
      tick();
      check("starve_no_dout", bus.dout_valid, 1'b0);
    end
    bus.ks_valid = 1'b1;
    bus.ks_data  = 8'hFF;
    tick();
    bus.ks_valid = 1'b0;
    #1;
    check("starve_ready_after_push", bus.din_ready, 1'b1);
    tick();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
    check("starve_valid", bus.dout_valid, 1'b1);
    check("starve_dout", bus.dout_data, 8'hF0);
    check("starve_last", bus.dout_last, 1'b1);
    tick();
    check("starve_done", done, 1'b1);
    tick();

    // Backpressure: 5-cycle dout stall mid-message
    ks_vec[0] = 8'h10; ks_vec[1] = 8'h20; ks_vec[2] = 8'h30;
    ks_vec[3] = 8'h40; ks_vec[4] = 8'h50; ks_vec[5] = 8'h60;
    push_ks(0, 6);
    for (int i = 0; i < 6; i++) din_vec[i] = 8'(i + 1);
    exp_vec[0] = 8'h11; exp_vec[1] = 8'h22; exp_vec[2] = 8'h33;
    exp_vec[3] = 8'h44; exp_vec[4] = 8'h55; exp_vec[5] = 8'h66;
    stream("bp", 6, 6, 6, 3, 5);

    // FIFO full in IDLE, then 40 bytes across a pointer wrap
    for (int i = 0; i < 40; i++) begin
      ks_vec[i]  = 8'(i * 7 + 3);
      din_vec[i] = 8'(i * 13 + 1);
      exp_vec[i] = ks_vec[i] ^ din_vec[i];
    end
    push_ks(0, 16);
    check("full_ks_ready", bus.ks_ready, 1'b0);
    bus.ks_valid = 1'b1;
    bus.ks_data  = ks_vec[16];
    tick();
    bus.ks_valid = 1'b0;
    check("full_still_full", bus.ks_ready, 1'b0);
    stream("wrap", 40, 16, 40, 1000, 0);

    // Reset after 3 of 9 bytes
    for (int i = 0; i < 9; i++) ks_vec[i] = KAT_KS[i];
    push_ks(0, 9);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      bus.din_valid = 1'b1;
      bus.din_data  = KAT_PT[i];
      bus.din_last  = 1'b0;
      tick();
    end
    bus.din_valid = 1'b0;
    check("mid_cnt_before_rst", byte_cnt, 16'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pulse_start();
    bus.din_valid = 1'b1;
    bus.din_data  = 8'h00;
    #1;
    check("midrst_fifo_empty", bus.din_ready, 1'b0);
    bus.din_valid = 1'b0;
`ifdef RC4_DROP_EN
    for (int i = 0; i < 4; i++) ks_vec[i] = 8'hAA;
    push_ks(0, 4);
`endif
    for (int i = 0; i < 9; i++) begin
      ks_vec[i]  = KAT_KS[i];
      din_vec[i] = KAT_PT[i];
      exp_vec[i] = KAT_CT[i];
    end
    stream("rekey", 9, 0, 9, 1000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
